// File: rtl/rom_arb_pkg.sv
// Shared encodings and default widths for the instruction-ROM port arbiter.
// Shared by rom_port_arbiter and rom_arb_rdret.
package rom_arb_pkg;

    localparam int ARB_ADDR_W = 12;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_L = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/rom_arb_rdret.sv
// Read-return path: remembers who owns the read in flight and steers the
// ROM's one-cycle-late data to that requester, holding rdata between reads.
module rom_arb_rdret
    import rom_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue,
    input  arb_owner_e        rd_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_pending,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata
);

    logic              pend_q, pend_d;
    arb_owner_e        own_q, own_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

    always_comb begin
        pend_d     = rd_issue;
        own_d      = rd_issue ? rd_owner : own_q;
        rd_pending = pend_q;
        f_rvalid   = pend_q && (own_q == OWN_F);
        l_rvalid   = pend_q && (own_q == OWN_L);
        // Data is live on the return cycle, then held in the per-owner register.
        f_rdata_d  = f_rvalid ? mem_rdata : f_rdata_q;
        l_rdata_d  = l_rvalid ? mem_rdata : l_rdata_q;
        f_rdata    = f_rdata_d;
        l_rdata    = l_rdata_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            own_q     <= OWN_F;
            f_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            pend_q    <= pend_d;
            own_q     <= own_d;
            f_rdata_q <= f_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-port instruction ROM between CPU fetch and the program loader.
// Optional loader anti-starvation (fairness) enabled by defining ARB_FAIR_EN.
//
// Handshake: a requester holds req/addr/wdata stable until gnt; gnt is
// combinational in the request cycle; read data returns one cycle after gnt
// with rvalid high for exactly that cycle.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_mode,
    output logic              cpu_hold,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    arb_state_e state_q, state_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       rd_pending;
    logic       rd_issue;
    arb_owner_e rd_owner;

`ifdef ARB_FAIR_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starve_hit;

    assign starve_hit = (starve_q == STARVE_W'(STARVE_MAX));

    always_comb begin
        // Count only fetch grants that made a waiting loader lose; anything else resets.
        starve_d = '0;
        if ((state_q == S_RUN) && l_req && f_gnt && !l_gnt) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
`endif

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        case (state_q)
            S_BOOT: begin
                l_gnt = l_req;
            end
            S_RUN: begin
`ifdef ARB_FAIR_EN
                if (f_req && l_req && starve_hit) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt = f_req;
                    l_gnt = l_req && !f_req;
                end
`else
                f_gnt = f_req;
                l_gnt = l_req && !f_req;
`endif
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        mem_en    = f_gnt | l_gnt;
        mem_we    = l_gnt & l_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end else if (f_gnt) begin
            mem_addr  = f_addr;
        end
        rd_issue = f_gnt | (l_gnt & ~l_we);
        rd_owner = l_gnt ? OWN_L : OWN_F;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  if (!boot_mode && !rd_pending) state_d = S_RUN;
            S_RUN:   if (boot_mode) state_d = S_DRAIN;
            S_DRAIN: state_d = S_BOOT;
            default: state_d = S_BOOT;
        endcase
        // Hold drops one edge after S_RUN is entered and rises with the exit edge.
        cpu_hold_d = (state_q != S_RUN) || boot_mode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign cpu_hold  = cpu_hold_q;
    assign dbg_state = state_q;

    rom_arb_rdret #(
        .DATA_W(DATA_W)
    ) u_rdret (
        .clk       (clk),
        .rst       (rst),
        .rd_issue  (rd_issue),
        .rd_owner  (rd_owner),
        .mem_rdata (mem_rdata),
        .rd_pending(rd_pending),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata)
    );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter with a behavioural synchronous ROM.
// Covers boot load, release, fetch streaming, conflicts, re-boot, async reset and fairness.
module tb_rom_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic              boot_mode;
    logic              cpu_hold;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] rom     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] f_exp_q [$];
    logic [DATA_W-1:0] l_exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    rom_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_MAX(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .boot_mode(boot_mode),
        .cpu_hold (cpu_hold),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Synchronous single-port ROM, 1-cycle read latency
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) rom[mem_addr] <= mem_wdata;
            mem_rdata <= rom[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: expected read data is taken from the reference image at grant time
    always @(negedge clk) begin
        if (!rst) begin
            if (f_gnt) f_exp_q.push_back(ref_mem[f_addr]);
            if (l_gnt) begin
                if (l_we) ref_mem[l_addr] = l_wdata;
                else      l_exp_q.push_back(ref_mem[l_addr]);
            end
        end
    end

    // Scoreboard pop on every returned read
    always @(negedge clk) begin
        if (f_rvalid) begin
            if (f_exp_q.size() == 0) check("f_rvalid_unexpected", 32'(f_rvalid), 32'd0);
            else check("f_rdata", f_rdata, f_exp_q.pop_front());
        end
        if (l_rvalid) begin
            if (l_exp_q.size() == 0) check("l_rvalid_unexpected", 32'(l_rvalid), 32'd0);
            else check("l_rdata", l_rdata, l_exp_q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            rom[i]     = 32'hA000_0000 | 32'(i);
            ref_mem[i] = 32'hA000_0000 | 32'(i);
        end
        rst = 1'b1; boot_mode = 1'b1;
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

        #20;
        check("rst_state", 32'(dbg_state), 32'(ST_BOOT));
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        check("rst_l_rvalid", 32'(l_rvalid), 32'd0);
        check("rst_f_rdata", f_rdata, 32'd0);
        check("rst_l_rdata", l_rdata, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        #10;
        rst = 1'b0;
        step();

        // Boot load: fetch requests are ignored while the loader writes the image
        for (int a = 0; a < 4; a++) begin
            f_req = 1'b1; f_addr = '0;
            l_req = 1'b1; l_we = 1'b1; l_addr = ADDR_W'(a); l_wdata = 32'h0000_0013;
            @(negedge clk);
            check("boot_l_gnt", 32'(l_gnt), 32'd1);
            check("boot_f_gnt", 32'(f_gnt), 32'd0);
            check("boot_mem_we", 32'(mem_we), 32'd1);
            check("boot_cpu_hold", 32'(cpu_hold), 32'd1);
            step();
        end
        l_we = 1'b0; l_addr = 12'd2;
        @(negedge clk);
        check("boot_rd_gnt", 32'(l_gnt), 32'd1);
        step();
        l_req = 1'b0; f_req = 1'b0;
        @(negedge clk);
        check("boot_l_rvalid", 32'(l_rvalid), 32'd1);
        check("boot_cpu_hold2", 32'(cpu_hold), 32'd1);
        step();

        // Release: hold drops two edges after boot_mode falls
        boot_mode = 1'b0;
        step();
        @(negedge clk);
        check("rel_state", 32'(dbg_state), 32'(ST_RUN));
        check("rel_hold_edge1", 32'(cpu_hold), 32'd1);
        step();
        @(negedge clk);
        check("rel_hold_edge2", 32'(cpu_hold), 32'd0);
        step();

        // Back-to-back fetch of the loaded words
        for (int i = 0; i < 4; i++) begin
            f_req = (i < 3); f_addr = ADDR_W'(i);
            @(negedge clk);
            if (i < 3) check("stream_f_gnt", 32'(f_gnt), 32'd1);
            if (i > 0) check("stream_f_rvalid", 32'(f_rvalid), 32'd1);
            step();
        end

        // Conflict: fetch wins, loader goes when fetch drops
        f_req = 1'b1; f_addr = 12'd7;
        l_req = 1'b1; l_we = 1'b0; l_addr = 12'd5;
        @(negedge clk);
        check("conf_f_gnt", 32'(f_gnt), 32'd1);
        check("conf_l_gnt", 32'(l_gnt), 32'd0);
        step();
        f_req = 1'b0;
        @(negedge clk);
        check("conf_l_gnt2", 32'(l_gnt), 32'd1);
        check("conf_mem_addr", 32'(mem_addr), 32'd5);
        step();
        l_req = 1'b0;
        @(negedge clk);
        check("conf_l_rvalid", 32'(l_rvalid), 32'd1);
        check("conf_f_rvalid", 32'(f_rvalid), 32'd0);
        check("idle_mem_addr", 32'(mem_addr), 32'd0);
        step();

        // Re-boot with a fetch in flight
        f_req = 1'b1; f_addr = 12'd1;
        @(negedge clk);
        check("reboot_f_gnt", 32'(f_gnt), 32'd1);
        step();
        f_req = 1'b0; boot_mode = 1'b1;
        @(negedge clk);
        check("reboot_f_rvalid", 32'(f_rvalid), 32'd1);
        check("reboot_hold_run", 32'(cpu_hold), 32'd0);
        step();
        f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 12'd3;
        @(negedge clk);
        check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        check("drain_f_gnt", 32'(f_gnt), 32'd0);
        check("drain_l_gnt", 32'(l_gnt), 32'd0);
        check("drain_hold", 32'(cpu_hold), 32'd1);
        step();
        @(negedge clk);
        check("reboot_state", 32'(dbg_state), 32'(ST_BOOT));
        check("reboot_l_gnt", 32'(l_gnt), 32'd1);
        check("reboot_f_gnt0", 32'(f_gnt), 32'd0);
        step();
        f_req = 1'b0; l_req = 1'b0; boot_mode = 1'b0;
        @(negedge clk);
        check("reboot_l_rvalid", 32'(l_rvalid), 32'd1);
        step();
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        check("rerun_hold", 32'(cpu_hold), 32'd0);
        step();

        // Async reset between a fetch grant and its return
        f_req = 1'b1; f_addr = 12'd2;
        @(negedge clk);
        check("mid_f_gnt", 32'(f_gnt), 32'd1);
        #2;
        rst = 1'b1; f_req = 1'b0;
        #1;
        check("async_hold", 32'(cpu_hold), 32'd1);
        check("async_f_rvalid", 32'(f_rvalid), 32'd0);
        check("async_l_rvalid", 32'(l_rvalid), 32'd0);
        check("async_state", 32'(dbg_state), 32'(ST_BOOT));
        check("async_f_rdata", f_rdata, 32'd0);
        f_exp_q.delete();
        l_exp_q.delete();
        step();
        check("post_rst_f_rvalid", 32'(f_rvalid), 32'd0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        check("post_rst_hold", 32'(cpu_hold), 32'd0);
        check("post_rst_f_rvalid2", 32'(f_rvalid), 32'd0);
        step();

        // Sustained contention: fairness pattern or strict fetch priority
        f_req = 1'b1; f_addr = 12'd1;
        l_req = 1'b1; l_we = 1'b0; l_addr = 12'd5;
        for (int i = 0; i < 18; i++) begin
            logic exp_l;
`ifdef ARB_FAIR_EN
            exp_l = ((i % 9) == 8);
`else
            exp_l = 1'b0;
`endif
            @(negedge clk);
            check($sformatf("fair_l_gnt_%0d", i), 32'(l_gnt), 32'(exp_l));
            check($sformatf("fair_f_gnt_%0d", i), 32'(f_gnt), 32'(!exp_l));
            step();
        end
        f_req = 1'b0; l_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("end_f_q_empty", 32'(f_exp_q.size()), 32'd0);
        check("end_l_q_empty", 32'(l_exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port instruction ROM between two requesters: the CPU fetch stage and the program loader.
- The loader is a test/boot master that writes test images such as rv32ui-p-* and reads them back.
- Sits between risc_v_top's fetch port and rom. It sequences boot (loader-exclusive, CPU held) and run (fetch-priority) phases, and routes read data back to the correct requester.

Parameters:
- ADDR_W, 12, word address width of the ROM.
- DATA_W, 32, data width.
- STARVE_MAX, 8, consecutive fetch grants with loader waiting before the loader is forced through (ARB_FAIR_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- boot_mode  in  1  1 = loader owns ROM exclusively, CPU held
- cpu_hold  out  1  stall to risc_v_top; registered
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  ADDR_W  loader word address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DATA_W  loader read data
- mem_en  out  1  ROM access enable
- mem_we  out  1  ROM write enable
- mem_addr  out  ADDR_W  ROM address
- mem_wdata  out  DATA_W  ROM write data
- mem_rdata  in  DATA_W  ROM read data, synchronous, 1-cycle latency

Behaviour:
- Reset (async, rst=1):
  - state=S_BOOT; cpu_hold=1.
  - f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0.
  - Pending read and starve counter cleared.
- States:
  - S_BOOT: only the loader is served; f_gnt=0; cpu_hold=1.
  - S_RUN: fetch has priority; loader is served when f_req=0; cpu_hold=0.
  - S_DRAIN: one cycle, no grants; lets an outstanding read retire; cpu_hold=1.
- Transitions:
  - S_BOOT→S_RUN when boot_mode=0 and no read pending; cpu_hold falls the cycle after entering S_RUN.
  - S_RUN→S_DRAIN when boot_mode=1; cpu_hold rises on the next edge.
  - S_DRAIN→S_BOOT unconditionally.
- Grants are combinational, same cycle as the request:
  - At most one of f_gnt/l_gnt is high.
  - mem_en = f_gnt|l_gnt; mem_we = l_gnt&l_we.
  - mem_addr/mem_wdata come from the granted requester; when nothing is granted they are 0.
- Read return: on a granted read, register owner+pending. Next cycle, the owner's rvalid=1 for exactly one cycle and its rdata is loaded with mem_rdata.
  - rdata holds its value otherwise.
  - Writes produce no rvalid.
- Fetch can issue back-to-back reads: gnt every cycle gives rvalid every cycle.
- Same-cycle write then read of the same address: the read, granted later, sees the new data.
- A boot_mode change with a read in flight does not cancel it: data still returns to its owner.
- Reset mid-read: the pending read is dropped; no rvalid after reset.
- Requesters must hold req/addr/wdata stable until gnt.

Optional Feature:
- Macro: ARB_FAIR_EN.
- With it: a starve counter, width $clog2(STARVE_MAX+1), increments each S_RUN cycle where l_req=1 and f_gnt=1. It clears on l_gnt or when l_req=0.
  - When counter==STARVE_MAX, the loader wins the next conflict: l_gnt=1, f_gnt=0, counter cleared.
- Without it: strict fetch priority in S_RUN; the loader may starve indefinitely; no counter logic.

Decomposition:
- Shared package rom_arb_pkg holds:
  - state encoding constants S_BOOT=2'd0, S_RUN=2'd1, S_DRAIN=2'd2;
  - owner encoding OWN_F=1'b0, OWN_L=1'b1;
  - default ADDR_W/DATA_W.
- One natural sub-module: rom_arb_rdret, the pending/owner register plus rvalid/rdata steering.
- The FSM and grant logic stay in the top.

Test Plan:
- Reset then boot load: rst=1 for 30 ns, boot_mode=1; the loader writes 0x00000013 to addr 0..3 and reads back addr 2.
  - l_gnt every cycle; f_gnt=0 with f_req=1.
  - l_rvalid one cycle later with l_rdata=0x00000013; cpu_hold=1 throughout.
- Release: boot_mode 1→0 → cpu_hold=0 two edges later.
  - Then fetch of addr 0,1,2 back-to-back → f_rvalid on 3 consecutive cycles with the loaded words.
- Conflict: f_req=1 and l_req=1 (read addr 5) in S_RUN → f_gnt=1, l_gnt=0.
  - Drop f_req → l_gnt=1 that cycle; l_rvalid next cycle; f_rvalid stays 0.
- Re-boot with a fetch in flight: boot_mode=1 in the cycle after f_gnt.
  - f_rvalid=1 still delivered; one S_DRAIN cycle with no grants, then S_BOOT with cpu_hold=1.
- Async reset mid-read: assert rst between a grant and its return.
  - f_rvalid=0, l_rvalid=0, cpu_hold=1 immediately, without waiting for a clock edge.
- ARB_FAIR_EN, STARVE_MAX=8: f_req and l_req held high → 8 fetch grants, then 1 loader grant, then the pattern repeats. Without the macro: fetch grants only.
